// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner sharing one 3-bit segment decoder.
// Frames are double-buffered (shadow -> active) and swapped only at frame start.
module seg_scan_ctrl #(
   parameter int unsigned GAP_CYC = 2,
   parameter int unsigned ON_CYC  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [11:0] data_in,
   input  logic        blank,
   output logic        ready,
   output logic [2:0]  dec_inp,
   output logic [3:0]  digit_en,
   output logic        frame_done,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GAP   = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);
   localparam logic [7:0] ON_LAST  = 8'(ON_CYC - 1);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [11:0] active_q, active_d;
   logic [11:0] shadow_q, shadow_d;
   logic        pending_q, pending_d;
   logic        ready_q, ready_d;
   logic [2:0]  dec_inp_q, dec_inp_d;
   logic [3:0]  digit_en_q, digit_en_d;
   logic        frame_done_q, frame_done_d;
   logic        commit;
   logic [2:0]  code_sel;

   // Handshake: a load is taken on any cycle where load && ready; ready stays
   // low while a frame is pending and rises the cycle after that frame commits.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      active_d     = active_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      frame_done_d = 1'b0;
      commit       = 1'b0;

      if (load && ready_q) begin
         shadow_d  = data_in;
         pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            idx_d  = 2'd0;
            cnt_d  = 8'd0;
            commit = pending_q;
            if (!blank) state_d = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_DRIVE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DRIVE: begin
            if (cnt_q == ON_LAST) begin
               state_d = S_GAP;
               cnt_d   = 8'd0;
               if (idx_q == 2'd3) begin
                  idx_d        = 2'd0;
                  frame_done_d = 1'b1;
                  commit       = pending_q;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = 8'd0;
         end
      endcase

      // Blank aborts the frame: no completion pulse and no mid-scan swap.
      if (blank) begin
         state_d      = S_IDLE;
         idx_d        = 2'd0;
         cnt_d        = 8'd0;
         frame_done_d = 1'b0;
         if (state_q != S_IDLE) commit = 1'b0;
      end

      if (commit) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end

      ready_d = !pending_d;
   end

   always_comb begin
      code_sel = 3'd0;
      case (idx_d)
         2'd0: code_sel = active_d[2:0];
         2'd1: code_sel = active_d[5:3];
         2'd2: code_sel = active_d[8:6];
         2'd3: code_sel = active_d[11:9];
         default: code_sel = 3'd0;
      endcase
      digit_en_d = 4'd0;
      dec_inp_d  = 3'd0;
      if (state_d == S_DRIVE) begin
         digit_en_d = 4'b0001 << idx_d;
         dec_inp_d  = code_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= 2'd0;
         cnt_q        <= 8'd0;
         active_q     <= 12'd0;
         shadow_q     <= 12'd0;
         pending_q    <= 1'b0;
         ready_q      <= 1'b1;
         dec_inp_q    <= 3'd0;
         digit_en_q   <= 4'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         ready_q      <= ready_d;
         dec_inp_q    <= dec_inp_d;
         digit_en_q   <= digit_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign ready      = ready_q;
   assign dec_inp    = dec_inp_q;
   assign digit_en   = digit_en_q;
   assign frame_done = frame_done_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed + randomized bench for seg_scan_ctrl against a frame-position model.
module tb_seg_scan_ctrl;

   localparam int G = 2;
   localparam int O = 8;
   localparam int P = G + O;
   localparam int F = 4 * P;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [11:0] data_in = 12'd0;
   logic        blank = 1'b1;
   logic        ready;
   logic [2:0]  dec_inp;
   logic [3:0]  digit_en;
   logic        frame_done;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // Model: scan position within the frame, plus the double buffer.
   bit          m_run;
   int          m_pos;
   bit          m_done;
   logic [11:0] m_active;
   logic [11:0] m_shadow;
   bit          m_pend;

   seg_scan_ctrl #(.GAP_CYC(G), .ON_CYC(O)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .data_in    (data_in),
      .blank      (blank),
      .ready      (ready),
      .dec_inp    (dec_inp),
      .digit_en   (digit_en),
      .frame_done (frame_done),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit wrap;
      if (reset) begin
         m_run = 0; m_pos = 0; m_done = 0;
         m_active = '0; m_shadow = '0; m_pend = 0;
         return;
      end
      wrap   = m_run && !blank && (m_pos == F - 1);
      m_done = wrap;
      if (m_pend && (!m_run || wrap)) begin
         m_active = m_shadow;
         m_pend   = 0;
      end else if (load && !m_pend) begin
         m_shadow = data_in;
         m_pend   = 1;
      end
      if (blank) begin
         m_run = 0; m_pos = 0;
      end else if (!m_run) begin
         m_run = 1; m_pos = 0;
      end else begin
         m_pos = (m_pos + 1) % F;
      end
   endtask

   task automatic check_outputs();
      logic [11:0] exp_en, exp_dec;
      int d, w;
      exp_en = '0;
      exp_dec = '0;
      if (m_run) begin
         d = m_pos / P;
         w = m_pos % P;
         if (w >= G) begin
            exp_en  = 12'(1 << d);
            exp_dec = (m_active >> (3 * d)) & 12'h7;
         end
      end
      chk("digit_en", {8'd0, digit_en}, exp_en);
      chk("dec_inp", {9'd0, dec_inp}, exp_dec);
      chk("frame_done", {11'd0, frame_done}, {11'd0, m_done});
      chk("ready", {11'd0, ready}, {11'd0, !m_pend});
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance to the middle of digit d's drive window, bounded.
   task automatic wait_drive(input int d, input string tag);
      bit found = 0;
      for (int i = 0; i < 3 * F && !found; i++) begin
         if (m_run && (m_pos / P == d) && (m_pos % P == G + 2)) found = 1;
         else step();
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL %s observed=timeout expected=drive_of_digit_%0d", tag, d);
      end
   endtask

   initial begin
      int pulses;

      // Reset, then commit a frame while blanked in IDLE.
      reset = 1; blank = 1; load = 1; data_in = 12'hFFF;
      run(2);
      reset = 0; load = 0;
      run(2);
      load = 1; data_in = 12'b011_010_001_000;
      step();
      load = 0;
      run(3);

      // Free run: order 0..3, codes 0..3, 2 dark + 8 lit cycles each.
      blank = 0;
      run(50);
      pulses = 0;
      for (int i = 0; i < 120; i++) begin
         step();
         if (frame_done) pulses++;
      end
      chk("frame_done_per_120", 12'(pulses), 12'd3);

      // New frame loaded mid digit 2; a second load while not ready is dropped.
      wait_drive(2, "wait_d2");
      load = 1; data_in = 12'b001_000_011_010;
      step();
      data_in = 12'b000_000_000_000;
      run(2);
      load = 0;
      run(2 * F);

      // Blank during digit 1 drive, then restart from digit 0.
      wait_drive(1, "wait_d1");
      blank = 1;
      run(4);
      blank = 0;
      run(F + 5);

      // Error-glyph codes pass straight through.
      load = 1; data_in = 12'b111_110_101_100;
      step();
      load = 0;
      run(2 * F + 5);

      // Reset mid-drive with a frame pending: shadow must never appear.
      load = 1; data_in = 12'b010_010_010_010;
      step();
      load = 0;
      wait_drive(1, "wait_rst");
      reset = 1; load = 1; blank = 0; data_in = 12'b011_011_011_011;
      step();
      reset = 0; load = 0;
      run(F + 5);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         load    = ($urandom_range(0, 9) == 0);
         data_in = 12'($urandom);
         if ($urandom_range(0, 99) < 2) blank = ~blank;
         reset   = ($urandom_range(0, 599) == 0);
         step();
      end
      reset = 0; load = 0; blank = 0;
      run(F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
